// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: datapath widths, operand-select encodings
// and the ALU control opcodes used by the EX stage and the ALU.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CTRL_W  = 5;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2,
    A_SEL_RSVD = 2'd3
  } a_sel_e;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b00001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 5'b00010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 5'b00011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b00100;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b00101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b00110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 5'b00111;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b01000;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 5'b01001;

endpackage

// File: rtl/fwd_mux.sv
// Single-source forward resolver: picks EX/MEM, then MEM/WB, then the
// captured register-file data for one source operand. x0 is never forwarded.
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]    i_cap_data,
  input  logic               i_exmem_we,
  input  logic [RADDR_W-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]    i_exmem_data,
  input  logic               i_memwb_we,
  input  logic [RADDR_W-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]    i_memwb_data,
  output logic [XLEN-1:0]    o_data,
  output logic               o_memwb_hit
);

  logic w_src_nz;
  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_src_nz    = (i_addr != {RADDR_W{1'b0}});
  assign w_exmem_hit = i_exmem_we & (i_exmem_rd == i_addr) & w_src_nz;
  assign w_memwb_hit = i_memwb_we & (i_memwb_rd == i_addr) & w_src_nz;
  assign o_memwb_hit = w_memwb_hit;

  // Youngest producer wins.
  always_comb begin
    o_data = i_cap_data;
    if (w_exmem_hit) begin
      o_data = i_exmem_data;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_data;
    end else begin
      o_data = i_cap_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and ALU source
// select. Forwarding is combinational from the registered slot and live buses.
module ex_operand_stage #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int RADDR_W = cpu_pkg::RADDR_W,
  parameter int CTRL_W  = cpu_pkg::CTRL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_reg_write,
  input  logic [CTRL_W-1:0]  id_alu_ctrl,
  input  logic [1:0]         id_a_sel,
  input  logic               id_b_sel,
  input  logic               stall,
  input  logic               flush,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd_addr,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd_addr,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_valid
);

  import cpu_pkg::*;

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [RADDR_W-1:0] r_rs1_addr;
  logic [RADDR_W-1:0] r_rs2_addr;
  logic [XLEN-1:0]    r_rs1_data;
  logic [XLEN-1:0]    r_rs2_data;
  logic [XLEN-1:0]    r_imm;
  logic [RADDR_W-1:0] r_rd_addr;
  logic               r_reg_write;
  logic [CTRL_W-1:0]  r_alu_ctrl;
  a_sel_e             r_a_sel;
  b_sel_e             r_b_sel;

  logic [XLEN-1:0]    w_fwd_rs1;
  logic [XLEN-1:0]    w_fwd_rs2;
  logic               w_rs1_memwb_hit;
  logic               w_rs2_memwb_hit;
  logic [XLEN-1:0]    w_alu_a;
  logic [XLEN-1:0]    w_alu_b;

  // Slot update: flush still loads ID fields but kills valid/reg_write.
  // A stalled slot absorbs MEM/WB writebacks so they survive retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= {XLEN{1'b0}};
      r_rs1_addr  <= {RADDR_W{1'b0}};
      r_rs2_addr  <= {RADDR_W{1'b0}};
      r_rs1_data  <= {XLEN{1'b0}};
      r_rs2_data  <= {XLEN{1'b0}};
      r_imm       <= {XLEN{1'b0}};
      r_rd_addr   <= {RADDR_W{1'b0}};
      r_reg_write <= 1'b0;
      r_alu_ctrl  <= {CTRL_W{1'b0}};
      r_a_sel     <= A_SEL_RS1;
      r_b_sel     <= B_SEL_RS2;
    end else if (flush || !stall) begin
      r_valid     <= id_valid & ~flush;
      r_pc        <= id_pc;
      r_rs1_addr  <= id_rs1_addr;
      r_rs2_addr  <= id_rs2_addr;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rd_addr   <= id_rd_addr;
      r_reg_write <= id_reg_write & id_valid & ~flush;
      r_alu_ctrl  <= id_alu_ctrl;
      r_a_sel     <= a_sel_e'(id_a_sel);
      r_b_sel     <= b_sel_e'(id_b_sel);
    end else begin
      if (w_rs1_memwb_hit) begin
        r_rs1_data <= memwb_result;
      end
      if (w_rs2_memwb_hit) begin
        r_rs2_data <= memwb_result;
      end
    end
  end

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .i_addr       (r_rs1_addr),
    .i_cap_data   (r_rs1_data),
    .i_exmem_we   (exmem_reg_write),
    .i_exmem_rd   (exmem_rd_addr),
    .i_exmem_data (exmem_result),
    .i_memwb_we   (memwb_reg_write),
    .i_memwb_rd   (memwb_rd_addr),
    .i_memwb_data (memwb_result),
    .o_data       (w_fwd_rs1),
    .o_memwb_hit  (w_rs1_memwb_hit)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .i_addr       (r_rs2_addr),
    .i_cap_data   (r_rs2_data),
    .i_exmem_we   (exmem_reg_write),
    .i_exmem_rd   (exmem_rd_addr),
    .i_exmem_data (exmem_result),
    .i_memwb_we   (memwb_reg_write),
    .i_memwb_rd   (memwb_rd_addr),
    .i_memwb_data (memwb_result),
    .o_data       (w_fwd_rs2),
    .o_memwb_hit  (w_rs2_memwb_hit)
  );

  // Operand A source; the reserved encoding reads as zero.
  always_comb begin
    w_alu_a = {XLEN{1'b0}};
    case (r_a_sel)
      A_SEL_RS1:  w_alu_a = w_fwd_rs1;
      A_SEL_PC:   w_alu_a = r_pc;
      A_SEL_ZERO: w_alu_a = {XLEN{1'b0}};
      default:    w_alu_a = {XLEN{1'b0}};
    endcase
  end

  // Operand B source.
  always_comb begin
    w_alu_b = w_fwd_rs2;
    if (r_b_sel == B_SEL_IMM) begin
      w_alu_b = r_imm;
    end else begin
      w_alu_b = w_fwd_rs2;
    end
  end

  assign alu_a         = w_alu_a;
  assign alu_b         = w_alu_b;
  assign alu_ctrl      = r_alu_ctrl;
  assign ex_store_data = w_fwd_rs2;
  assign ex_pc         = r_pc;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_reg_write  = r_reg_write & r_valid;
  assign ex_valid      = r_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed vectors with literal
// expectations plus a behavioural slot model compared on every falling edge.
module tb_ex_operand_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_reg_write;
  logic [4:0]  id_alu_ctrl;
  logic [1:0]  id_a_sel;
  logic        id_b_sel;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [4:0]  alu_ctrl, ex_rd_addr;
  logic        ex_reg_write, ex_valid;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_alu_ctrl(id_alu_ctrl), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
    .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
  );

  // Model of the instruction occupying the EX slot.
  typedef struct {
    logic        valid;
    logic        rw;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd, ctrl;
    logic [1:0]  asel;
    logic        bsel;
  } slot_t;
  slot_t m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exmem_hits(input logic [4:0] a);
    return exmem_reg_write && exmem_rd_addr == a && a != 5'd0;
  endfunction

  function automatic logic memwb_hits(input logic [4:0] a);
    return memwb_reg_write && memwb_rd_addr == a && a != 5'd0;
  endfunction

  // Value a source register holds right now, given the newest producer.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] cap);
    if (exmem_hits(a)) return exmem_result;
    if (memwb_hits(a)) return memwb_result;
    return cap;
  endfunction

  // Model update at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m.valid <= 1'b0; m.rw <= 1'b0; m.pc <= 32'd0; m.rs1d <= 32'd0;
      m.rs2d <= 32'd0; m.imm <= 32'd0; m.rs1a <= 5'd0; m.rs2a <= 5'd0;
      m.rd <= 5'd0; m.ctrl <= 5'd0; m.asel <= 2'd0; m.bsel <= 1'b0;
    end else if (stall && !flush) begin
      if (memwb_hits(m.rs1a)) m.rs1d <= memwb_result;
      if (memwb_hits(m.rs2a)) m.rs2d <= memwb_result;
    end else begin
      m.valid <= id_valid && !flush;
      m.rw    <= id_valid && id_reg_write && !flush;
      m.pc <= id_pc; m.rs1d <= id_rs1_data; m.rs2d <= id_rs2_data;
      m.imm <= id_imm; m.rs1a <= id_rs1_addr; m.rs2a <= id_rs2_addr;
      m.rd <= id_rd_addr; m.ctrl <= id_alu_ctrl; m.asel <= id_a_sel;
      m.bsel <= id_b_sel;
    end
  end

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] ea;
      logic [31:0] rs2v;
      rs2v = operand(m.rs2a, m.rs2d);
      ea = (m.asel == 2'd0) ? operand(m.rs1a, m.rs1d) :
           (m.asel == 2'd1) ? m.pc : 32'd0;
      check("m_alu_a", alu_a, ea);
      check("m_alu_b", alu_b, m.bsel ? m.imm : rs2v);
      check("m_store", ex_store_data, rs2v);
      check("m_ctrl", {27'd0, alu_ctrl}, {27'd0, m.ctrl});
      check("m_pc", ex_pc, m.pc);
      check("m_rd", {27'd0, ex_rd_addr}, {27'd0, m.rd});
      check("m_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      check("m_rw", {31'd0, ex_reg_write}, {31'd0, m.valid & m.rw});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_idle();
    exmem_reg_write = 1'b0; exmem_rd_addr = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd_addr = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [4:0] rd, input logic rw, input logic [4:0] ctrl,
                          input logic [1:0] asel, input logic bsel);
    id_valid = 1'b1; id_pc = pc; id_rs1_addr = r1; id_rs1_data = d1;
    id_rs2_addr = r2; id_rs2_data = d2; id_imm = imm; id_rd_addr = rd;
    id_reg_write = rw; id_alu_ctrl = ctrl; id_a_sel = asel; id_b_sel = bsel;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0);
    id_valid = 1'b0;
    bus_idle();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Plain load
    drive_id(32'h00001000, 5'd1, 32'hf0000000, 5'd2, 32'h90000000, 32'd0,
             5'd3, 1'b1, ALU_AND, 2'd0, 1'b0);
    tick();
    mid();
    check("plain_a", alu_a, 32'hf0000000);
    check("plain_b", alu_b, 32'h90000000);
    check("plain_ctrl", {27'd0, alu_ctrl}, 32'h00000002);
    check("plain_rw", {31'd0, ex_reg_write}, 32'd1);

    // Mid-stream reset for two cycles with a valid instruction in ID
    rst = 1'b1;
    tick();
    tick();
    mid();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_rw", {31'd0, ex_reg_write}, 32'd0);
    check("rst_ctrl", {27'd0, alu_ctrl}, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_a", alu_a, 32'd0);
    rst = 1'b0;

    // Forward priority on rs1=x5
    drive_id(32'h00002000, 5'd5, 32'h11111111, 5'd6, 32'h22222222, 32'd0,
             5'd7, 1'b1, ALU_ADD, 2'd0, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd5; exmem_result = 32'h004400ff;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd5; memwb_result = 32'hf0000fff;
    mid();
    check("fwd_exmem", alu_a, 32'h004400ff);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", alu_a, 32'hf0000fff);

    // x0 guard on rs2
    bus_idle();
    drive_id(32'h00003000, 5'd1, 32'h00000001, 5'd0, 32'd0, 32'd0,
             5'd8, 1'b1, ALU_OR, 2'd0, 1'b0);
    tick();
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'hdeadbeef;
    mid();
    check("x0_b", alu_b, 32'd0);
    check("x0_store", ex_store_data, 32'd0);

    // Stall refresh: MEM/WB writeback to rs1 retires mid-stall
    bus_idle();
    drive_id(32'h00004000, 5'd7, 32'h11111111, 5'd2, 32'h0, 32'd0,
             5'd9, 1'b1, ALU_SUB, 2'd0, 1'b0);
    tick();
    stall = 1'b1;
    drive_id(32'h00005000, 5'd3, 32'h0000abcd, 5'd4, 32'h00000444, 32'd0,
             5'd10, 1'b1, ALU_XOR, 2'd0, 1'b0);
    tick();
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd7; memwb_result = 32'h00000419;
    tick();
    bus_idle();
    tick();
    mid();
    check("stall_a", alu_a, 32'h00000419);
    check("stall_pc", ex_pc, 32'h00004000);
    stall = 1'b0;
    tick();
    mid();
    check("release_a", alu_a, 32'h0000abcd);
    check("release_pc", ex_pc, 32'h00005000);

    // Flush beats stall; immediate select
    drive_id(32'h00006000, 5'd1, 32'h0, 5'd9, 32'h12345678, 32'h00040004,
             5'd11, 1'b1, ALU_ADD, 2'd0, 1'b1);
    stall = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    mid();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    check("imm_b", alu_b, 32'h00040004);
    check("imm_store", ex_store_data, 32'h12345678);
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd9; memwb_result = 32'hcafef00d;
    #1;
    check("imm_store_fwd", ex_store_data, 32'hcafef00d);
    check("imm_b_hold", alu_b, 32'h00040004);
    tick();
    stall = 1'b0;
    bus_idle();

    // Invalid ID slot never produces reg_write
    drive_id(32'h00007000, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd12, 1'b1, ALU_ADD, 2'd1, 1'b0);
    id_valid = 1'b0;
    tick();
    mid();
    check("inv_rw", {31'd0, ex_reg_write}, 32'd0);
    check("pc_sel_a", alu_a, 32'h00007000);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 60; i++) begin
      drive_id($urandom, 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)),
               $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
               5'($urandom_range(0, 9)), 2'($urandom), 1'($urandom));
      id_valid = 1'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd_addr = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd_addr = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      tick();
    end
    mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
